// File: rtl/alarm_scheduler_pkg.sv
// Shared types and defaults for the alarm scheduler.
// State encoding plus default slot count and stamp width.
package alarm_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RING,
        SNOOZE
    } state_t;

    localparam int STAMP_W_DEF = 64;
    localparam int N_ALARM_DEF = 3;

endpackage

// File: rtl/alarm_slot_bank.sv
// Alarm stamp/armed storage with write port, read mux and match compare.
// A write to a slot suppresses that slot's match in the same cycle.
import alarm_scheduler_pkg::*;

module alarm_slot_bank #(
    parameter int N_ALARM = N_ALARM_DEF,
    parameter int STAMP_W = STAMP_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [STAMP_W-1:0] counter,
    input  logic               wr_en,
    input  logic [1:0]         wr_slot,
    input  logic [STAMP_W-1:0] wr_stamp,
    input  logic               wr_arm,
    input  logic [1:0]         rd_slot,
    output logic [STAMP_W-1:0] rd_stamp,
    output logic               rd_armed,
    output logic [N_ALARM-1:0] match
);

    logic [STAMP_W-1:0] stamp [N_ALARM];
    logic [N_ALARM-1:0] armed;
    logic [N_ALARM-1:0] wr_hit;

    always_comb begin
        wr_hit = '0;
        match  = '0;
        for (int i = 0; i < N_ALARM; i++) begin
            wr_hit[i] = wr_en && (wr_slot == 2'(i));
            match[i]  = tick && armed[i] && (stamp[i] == counter) && !wr_hit[i];
        end
    end

    always_comb begin
        rd_stamp = '0;
        rd_armed = 1'b0;
        for (int i = 0; i < N_ALARM; i++) begin
            if (rd_slot == 2'(i)) begin
                rd_stamp = stamp[i];
                rd_armed = armed[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ALARM; i++) begin
                stamp[i] <= '0;
            end
            armed <= '0;
        end else begin
            for (int i = 0; i < N_ALARM; i++) begin
                if (wr_hit[i]) begin
                    stamp[i] <= wr_stamp;
                    armed[i] <= wr_arm;
                end else if (match[i]) begin
                    armed[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/alarm_scheduler.sv
// One-shot alarm scheduler: pending queue, lowest-index service order,
// and the ring/snooze burst state machine driving the buzzer.
import alarm_scheduler_pkg::*;

module alarm_scheduler #(
    parameter int N_ALARM     = N_ALARM_DEF,
    parameter int STAMP_W     = STAMP_W_DEF,
    parameter int RING_SECS   = 5,
    parameter int SNOOZE_SECS = 10,
    parameter int MAX_BURSTS  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [STAMP_W-1:0] counter,
    input  logic               wr_en,
    input  logic [1:0]         wr_slot,
    input  logic [STAMP_W-1:0] wr_stamp,
    input  logic               wr_arm,
    input  logic [1:0]         rd_slot,
    output logic [STAMP_W-1:0] rd_stamp,
    output logic               rd_armed,
    input  logic               cancel,
    input  logic               snooze,
    output logic               ring,
    output logic [1:0]         ring_slot,
    output logic [N_ALARM-1:0] pending
);

    localparam int SEC_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int SEC_W   = (SEC_MAX < 2) ? 1 : $clog2(SEC_MAX);
    localparam int BURST_W = $clog2(MAX_BURSTS + 1);

    localparam logic [SEC_W-1:0]   RING_LAST   = SEC_W'(RING_SECS - 1);
    localparam logic [SEC_W-1:0]   SNOOZE_LAST = SEC_W'(SNOOZE_SECS - 1);
    localparam logic [BURST_W-1:0] BURST_LAST  = BURST_W'(MAX_BURSTS - 1);

    state_t             state;
    logic [SEC_W-1:0]   sec_cnt;
    logic [BURST_W-1:0] burst_cnt;

    logic [N_ALARM-1:0] match;
    logic [N_ALARM-1:0] wr_mask;
    logic [N_ALARM-1:0] avail;
    logic [N_ALARM-1:0] take;
    logic [1:0]         sel_idx;
    logic               sel_valid;
    logic               stop;
    logic               burst_end;

    alarm_slot_bank #(
        .N_ALARM (N_ALARM),
        .STAMP_W (STAMP_W)
    ) u_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .counter  (counter),
        .wr_en    (wr_en),
        .wr_slot  (wr_slot),
        .wr_stamp (wr_stamp),
        .wr_arm   (wr_arm),
        .rd_slot  (rd_slot),
        .rd_stamp (rd_stamp),
        .rd_armed (rd_armed),
        .match    (match)
    );

    // A write to a slot drops its pending bit, so it is never selected.
    always_comb begin
        wr_mask = '0;
        for (int i = 0; i < N_ALARM; i++) begin
            wr_mask[i] = wr_en && (wr_slot == 2'(i));
        end
        avail     = pending & ~wr_mask;
        sel_valid = |avail;
        sel_idx   = '0;
        for (int i = N_ALARM - 1; i >= 0; i--) begin
            if (avail[i]) sel_idx = 2'(i);
        end
        take      = (state == IDLE) ? (avail & (~avail + N_ALARM'(1))) : '0;
        stop      = cancel || (wr_en && (wr_slot == ring_slot));
        burst_end = snooze || (tick && (sec_cnt == RING_LAST));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ring      <= 1'b0;
            ring_slot <= '0;
            pending   <= '0;
            sec_cnt   <= '0;
            burst_cnt <= '0;
        end else begin
            pending <= (pending | match) & ~wr_mask & ~take;
            unique case (state)
                IDLE: begin
                    if (sel_valid) begin
                        ring_slot <= sel_idx;
                        sec_cnt   <= '0;
                        burst_cnt <= '0;
                        ring      <= 1'b1;
                        state     <= RING;
                    end
                end
                RING: begin
                    if (stop) begin
                        ring  <= 1'b0;
                        state <= IDLE;
                    end else if (burst_end) begin
                        sec_cnt   <= '0;
                        burst_cnt <= burst_cnt + BURST_W'(1);
                        ring      <= 1'b0;
                        state     <= (burst_cnt == BURST_LAST) ? IDLE : SNOOZE;
                    end else if (tick) begin
                        sec_cnt <= sec_cnt + SEC_W'(1);
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (sec_cnt == SNOOZE_LAST) begin
                            sec_cnt <= '0;
                            ring    <= 1'b1;
                            state   <= RING;
                        end else begin
                            sec_cnt <= sec_cnt + SEC_W'(1);
                        end
                    end
                end
                default: begin
                    ring  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed-vector bench for alarm_scheduler with default parameters.
// Each scenario task drives stimulus and checks hand-computed values.
module tb_alarm_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic [63:0] counter;
    logic        wr_en;
    logic [1:0]  wr_slot;
    logic [63:0] wr_stamp;
    logic        wr_arm;
    logic [1:0]  rd_slot;
    logic [63:0] rd_stamp;
    logic        rd_armed;
    logic        cancel;
    logic        snooze;
    logic        ring;
    logic [1:0]  ring_slot;
    logic [2:0]  pending;

    int          vectors = 0;
    int          errors  = 0;
    logic [63:0] now;

    always #5 clk = ~clk;

    alarm_scheduler dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .counter   (counter),
        .wr_en     (wr_en),
        .wr_slot   (wr_slot),
        .wr_stamp  (wr_stamp),
        .wr_arm    (wr_arm),
        .rd_slot   (rd_slot),
        .rd_stamp  (rd_stamp),
        .rd_armed  (rd_armed),
        .cancel    (cancel),
        .snooze    (snooze),
        .ring      (ring),
        .ring_slot (ring_slot),
        .pending   (pending)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        now     = now + 64'd1;
        counter = now;
        tick    = 1'b1;
        cyc();
        tick    = 1'b0;
    endtask

    task automatic write_slot(input logic [1:0] s, input logic [63:0] st,
                              input logic a);
        wr_en    = 1'b1;
        wr_slot  = s;
        wr_stamp = st;
        wr_arm   = a;
        cyc();
        wr_en    = 1'b0;
    endtask

    task automatic pulse_cancel();
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        vectors++;
        if (ring !== 1'b0) begin
            errors++;
            $display("FAIL reset_ring: got %0b want 0", ring);
        end
        vectors++;
        if (pending !== 3'b000) begin
            errors++;
            $display("FAIL reset_pending: got %b want 000", pending);
        end
        vectors++;
        if (ring_slot !== 2'd0) begin
            errors++;
            $display("FAIL reset_ring_slot: got %0d want 0", ring_slot);
        end
        for (int i = 0; i < 3; i++) begin
            rd_slot = 2'(i);
            #1;
            vectors++;
            if (rd_stamp !== 64'd0 || rd_armed !== 1'b0) begin
                errors++;
                $display("FAIL reset_slot%0d: got %0d/%0b want 0/0", i, rd_stamp, rd_armed);
            end
        end
    endtask

    task automatic test_match_latency();
        now     = 64'd98;
        counter = now;
        write_slot(2'd1, 64'd100, 1'b1);
        rd_slot = 2'd1;
        #1;
        vectors++;
        if (rd_stamp !== 64'd100 || rd_armed !== 1'b1) begin
            errors++;
            $display("FAIL write_read: got %0d/%0b want 100/1", rd_stamp, rd_armed);
        end
        do_tick();
        do_tick();
        vectors++;
        if (pending !== 3'b010 || ring !== 1'b0) begin
            errors++;
            $display("FAIL match_t1: got pend=%b ring=%0b want 010/0", pending, ring);
        end
        cyc();
        vectors++;
        if (ring !== 1'b1 || ring_slot !== 2'd1 || pending !== 3'b000) begin
            errors++;
            $display("FAIL match_t2: got ring=%0b slot=%0d pend=%b want 1/1/000",
                     ring, ring_slot, pending);
        end
        vectors++;
        if (rd_armed !== 1'b0) begin
            errors++;
            $display("FAIL one_shot: got armed=%0b want 0", rd_armed);
        end
        pulse_cancel();
        vectors++;
        if (ring !== 1'b0) begin
            errors++;
            $display("FAIL cancel_drop: got %0b want 0", ring);
        end
    endtask

    task automatic test_unattended();
        logic exp;
        logic prev;
        int   bursts;
        write_slot(2'd0, now + 64'd1, 1'b1);
        do_tick();
        cyc();
        vectors++;
        if (ring !== 1'b1 || ring_slot !== 2'd0) begin
            errors++;
            $display("FAIL unatt_start: got ring=%0b slot=%0d want 1/0", ring, ring_slot);
        end
        prev   = 1'b1;
        bursts = 1;
        for (int k = 1; k <= 50; k++) begin
            do_tick();
            exp = (k < 35) && ((k % 15) < 5);
            vectors++;
            if (ring !== exp) begin
                errors++;
                $display("FAIL unatt_tick%0d: got %0b want %0b", k, ring, exp);
            end
            if (ring === 1'b1 && prev === 1'b0) bursts++;
            prev = ring;
        end
        vectors++;
        if (bursts !== 3) begin
            errors++;
            $display("FAIL unatt_bursts: got %0d want 3", bursts);
        end
    endtask

    task automatic test_simultaneous();
        write_slot(2'd0, now + 64'd1, 1'b1);
        write_slot(2'd2, now + 64'd1, 1'b1);
        do_tick();
        vectors++;
        if (pending !== 3'b101) begin
            errors++;
            $display("FAIL simul_pend: got %b want 101", pending);
        end
        cyc();
        vectors++;
        if (ring !== 1'b1 || ring_slot !== 2'd0 || pending !== 3'b100) begin
            errors++;
            $display("FAIL simul_first: got ring=%0b slot=%0d pend=%b want 1/0/100",
                     ring, ring_slot, pending);
        end
        do_tick();
        do_tick();
        vectors++;
        if (pending !== 3'b100 || ring !== 1'b1) begin
            errors++;
            $display("FAIL simul_hold: got pend=%b ring=%0b want 100/1", pending, ring);
        end
        pulse_cancel();
        vectors++;
        if (ring !== 1'b0) begin
            errors++;
            $display("FAIL simul_gap: got %0b want 0", ring);
        end
        cyc();
        vectors++;
        if (ring !== 1'b1 || ring_slot !== 2'd2 || pending !== 3'b000) begin
            errors++;
            $display("FAIL simul_second: got ring=%0b slot=%0d pend=%b want 1/2/000",
                     ring, ring_slot, pending);
        end
        pulse_cancel();
    endtask

    task automatic test_snooze();
        write_slot(2'd1, now + 64'd1, 1'b1);
        do_tick();
        cyc();
        do_tick();
        do_tick();
        snooze = 1'b1;
        cyc();
        snooze = 1'b0;
        vectors++;
        if (ring !== 1'b0) begin
            errors++;
            $display("FAIL snooze_drop: got %0b want 0", ring);
        end
        vectors++;
        if (dut.burst_cnt !== 2'd1) begin
            errors++;
            $display("FAIL snooze_burst: got %0d want 1", dut.burst_cnt);
        end
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) begin
                snooze = 1'b1;
                cyc();
                snooze = 1'b0;
            end
            do_tick();
            vectors++;
            if (ring !== (k == 10)) begin
                errors++;
                $display("FAIL snooze_tick%0d: got %0b want %0b", k, ring, (k == 10));
            end
        end
        pulse_cancel();
    endtask

    task automatic test_cancel_snooze();
        write_slot(2'd2, now + 64'd1, 1'b1);
        do_tick();
        cyc();
        cancel = 1'b1;
        snooze = 1'b1;
        cyc();
        cancel = 1'b0;
        snooze = 1'b0;
        vectors++;
        if (ring !== 1'b0) begin
            errors++;
            $display("FAIL cs_drop: got %0b want 0", ring);
        end
        for (int k = 0; k < 15; k++) begin
            do_tick();
            vectors++;
            if (ring !== 1'b0) begin
                errors++;
                $display("FAIL cs_idle_tick%0d: got %0b want 0", k, ring);
            end
        end
    endtask

    task automatic test_write_cancel();
        write_slot(2'd1, now + 64'd1, 1'b1);
        do_tick();
        cyc();
        write_slot(2'd1, 64'd9999, 1'b0);
        vectors++;
        if (ring !== 1'b0) begin
            errors++;
            $display("FAIL wr_cancel: got %0b want 0", ring);
        end
        do_tick();
        vectors++;
        if (ring !== 1'b0 || pending !== 3'b000) begin
            errors++;
            $display("FAIL wr_cancel_idle: got ring=%0b pend=%b want 0/000", ring, pending);
        end
    endtask

    task automatic test_write_vs_match();
        write_slot(2'd2, now + 64'd1, 1'b1);
        now      = now + 64'd1;
        counter  = now;
        tick     = 1'b1;
        wr_en    = 1'b1;
        wr_slot  = 2'd2;
        wr_stamp = 64'd500000;
        wr_arm   = 1'b1;
        cyc();
        tick     = 1'b0;
        wr_en    = 1'b0;
        rd_slot  = 2'd2;
        #1;
        vectors++;
        if (pending !== 3'b000) begin
            errors++;
            $display("FAIL wvm_pend: got %b want 000", pending);
        end
        vectors++;
        if (rd_stamp !== 64'd500000 || rd_armed !== 1'b1) begin
            errors++;
            $display("FAIL wvm_slot: got %0d/%0b want 500000/1", rd_stamp, rd_armed);
        end
        cyc();
        vectors++;
        if (ring !== 1'b0) begin
            errors++;
            $display("FAIL wvm_ring: got %0b want 0", ring);
        end
    endtask

    task automatic test_ignored_write();
        write_slot(2'd3, 64'd777, 1'b1);
        for (int i = 0; i < 3; i++) begin
            rd_slot = 2'(i);
            #1;
            vectors++;
            if (rd_stamp === 64'd777) begin
                errors++;
                $display("FAIL ign_slot%0d: got %0d want not 777", i, rd_stamp);
            end
        end
        rd_slot = 2'd2;
        #1;
        vectors++;
        if (rd_stamp !== 64'd500000) begin
            errors++;
            $display("FAIL ign_keep: got %0d want 500000", rd_stamp);
        end
    endtask

    task automatic test_reset_mid();
        write_slot(2'd0, now + 64'd1, 1'b1);
        write_slot(2'd1, now + 64'd1, 1'b1);
        do_tick();
        cyc();
        do_tick();
        vectors++;
        if (ring !== 1'b1 || pending !== 3'b010) begin
            errors++;
            $display("FAIL rst_pre: got ring=%0b pend=%b want 1/010", ring, pending);
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        vectors++;
        if (ring !== 1'b0 || pending !== 3'b000 || ring_slot !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid: got ring=%0b pend=%b slot=%0d want 0/000/0",
                     ring, pending, ring_slot);
        end
        for (int i = 0; i < 3; i++) begin
            rd_slot = 2'(i);
            #1;
            vectors++;
            if (rd_stamp !== 64'd0 || rd_armed !== 1'b0) begin
                errors++;
                $display("FAIL rst_slot%0d: got %0d/%0b want 0/0", i, rd_stamp, rd_armed);
            end
        end
        cyc();
        vectors++;
        if (ring !== 1'b0) begin
            errors++;
            $display("FAIL rst_after: got %0b want 0", ring);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        tick     = 1'b0;
        counter  = '0;
        wr_en    = 1'b0;
        wr_slot  = '0;
        wr_stamp = '0;
        wr_arm   = 1'b0;
        rd_slot  = '0;
        cancel   = 1'b0;
        snooze   = 1'b0;
        now      = '0;
        test_reset();
        test_match_latency();
        test_unattended();
        test_simultaneous();
        test_snooze();
        test_cancel_snooze();
        test_write_cancel();
        test_write_vs_match();
        test_ignored_write();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
